nibble_add_sequencer: RTL and testbench

//   Multi-precision add controller that sits directly upstream of parallel_adder (4-bit, ports A/B/Ci -> S/Co).

---
 rtl/nibble_add_sequencer_if.sv | 32 +++
 rtl/nibble_add_sequencer.sv | 120 ++++++++++++
 tb/tb_nibble_add_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nibble_add_sequencer_if.sv
// Request/result bundle of nibble_add_sequencer. The ovf signal exists only when SEQ_OVERFLOW_EN is defined.
// start is honoured only while idle; done pulses one cycle and sum/cout (and ovf) stay valid until the next accepted start.
interface nibble_add_sequencer_if #(parameter int NIBBLES = 4);
   logic                 start;
   logic [4*NIBBLES-1:0] op_a;
   logic [4*NIBBLES-1:0] op_b;
   logic                 cin;
   logic [4*NIBBLES-1:0] sum;
   logic                 cout;
   logic                 busy;
   logic                 done;
   logic [1:0]           state;
`ifdef SEQ_OVERFLOW_EN
   logic                 ovf;
`endif

   modport master (
      output start, op_a, op_b, cin,
      input  sum, cout, busy, done, state
`ifdef SEQ_OVERFLOW_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output sum, cout, busy, done, state
`ifdef SEQ_OVERFLOW_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Multi-precision add controller: feeds a 4-bit combinational adder one nibble per clock, LSB first,
// chaining its carry. Define SEQ_OVERFLOW_EN to add the two's-complement overflow flag (bus.ovf).
module nibble_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_add_sequencer_if.slave bus,
   output logic [3:0]           A,
   output logic [3:0]           B,
   output logic                 Ci,
   input  logic [3:0]           S,
   input  logic                 Co
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          cin_reg;
   logic          carry_reg;
   logic [W-1:0]  sum_reg;
   logic          cout_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          last;
`ifdef SEQ_OVERFLOW_EN
   logic          ovf_reg;
`endif

   assign last = (idx == IW'(NIBBLES - 1));

   // Adder operands are only driven while running so the adder sees zeros when idle.
   always_comb begin
      A  = 4'd0;
      B  = 4'd0;
      Ci = 1'b0;
      if (state == RUN) begin
         A  = a_reg[{idx, 2'b00} +: 4];
         B  = b_reg[{idx, 2'b00} +: 4];
         Ci = (idx == '0) ? cin_reg : carry_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         cin_reg   <= 1'b0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  a_reg     <= bus.op_a;
                  b_reg     <= bus.op_b;
                  cin_reg   <= bus.cin;
                  carry_reg <= 1'b0;
                  idx       <= '0;
                  sum_reg   <= '0;
                  cout_reg  <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
                  ovf_reg   <= 1'b0;
`endif
                  busy_reg  <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum_reg[{idx, 2'b00} +: 4] <= S;
               carry_reg <= Co;
               if (last) begin
                  cout_reg <= Co;
`ifdef SEQ_OVERFLOW_EN
                  ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (S[3] != a_reg[W-1]);
`endif
                  idx      <= '0;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done_reg <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.sum   = sum_reg;
   assign bus.cout  = cout_reg;
   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;
   assign bus.state = state;
`ifdef SEQ_OVERFLOW_EN
   assign bus.ovf   = ovf_reg;
`endif
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer (NIBBLES=4) with a behavioural 4-bit adder and a done-driven scoreboard.
module tb_nibble_add_sequencer;
   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic       clk;
   logic       rst_n;
   logic [3:0] A, B, S;
   logic       Ci, Co;
   int         checks = 0;
   int         errors = 0;
   logic [W:0] exp_q[$];
`ifdef SEQ_OVERFLOW_EN
   logic       ovf_q[$];
`endif
   logic [7:0] ci_seen;

   nibble_add_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .A(A), .B(B), .Ci(Ci), .S(S), .Co(Co)
   );

   // Behavioural model of the downstream parallel_adder.
   always_comb {Co, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("sum", 32'(bus.sum), 32'(e[W-1:0]));
            chk("cout", 32'(bus.cout), 32'(e[W]));
`ifdef SEQ_OVERFLOW_EN
            chk("ovf", 32'(bus.ovf), 32'(ovf_q.pop_front()));
`endif
         end
      end
   end

   // driver: issue one operation, check busy window, latency and a single done pulse
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic hold,
                         input logic [W-1:0] es, input logic ec, input logic eo, output logic [7:0] cis);
      int n;
      @(negedge clk);
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = ci;
      bus.start = 1'b1;
      exp_q.push_back({ec, es});
`ifdef SEQ_OVERFLOW_EN
      ovf_q.push_back(eo);
`endif
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      bus.op_a = 16'hDEAD;
      bus.op_b = 16'hBEEF;
      bus.cin  = ~ci;
      cis = '0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
         chk("busy_in_run", 32'(bus.busy), 32'd1);
         if (n < 8) cis[n] = Ci;
         n++;
      end
      chk("latency", 32'(n), 32'(NIBBLES));
      bus.start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.cin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_adder_in", 32'({A, B, Ci}), 32'd0);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, ci_seen);
      chk("ci_seq_1234", 32'(ci_seen[3:0]), 32'h0);

      // mid-cycle reset clears the held result immediately
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sum", 32'(bus.sum), 32'd0);
      chk("async_rst_state", 32'(bus.state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_done_idle", 32'(bus.done), 32'd0);

      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, ci_seen);
      chk("ci_seq_ripple", 32'(ci_seen[3:0]), 32'hE);

      // start held high through RUN: one done only
      run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, ci_seen);
      chk("ci_seq_cin", 32'(ci_seen[3:0]), 32'h1);
      repeat (3) @(negedge clk);
      chk("no_reaccept", 32'(bus.busy), 32'd0);

      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, ci_seen);
      run_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, ci_seen);

      // abort after two RUN edges
      @(negedge clk);
      bus.op_a  = 16'hAAAA;
      bus.op_b  = 16'h5555;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_sum", 32'(bus.sum), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_adder_in", 32'({A, B, Ci}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, ci_seen);

`ifdef SEQ_OVERFLOW_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, ci_seen);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, ci_seen);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
